// File: rtl/ps2_scan_decoder_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        S_E0,
        S_F0
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam int         PS2_EVT_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard status/ack bytes that never carry a key code.
    function automatic logic is_filtered(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Key-event stream: valid/ready handshake plus the head event fields.
interface ps2_scan_decoder_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_brk,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_brk,
        output evt_ready
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; the head is held in a register so it
// keeps its last value once the FIFO drains.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic [WIDTH-1:0] head_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = head_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // Next head comes from memory unless the popped entry was the last one.
            if (do_pop) begin
                if (count > (PW+1)'(1)) begin
                    head_q <= mem[rd_ptr + PW'(1)];
                end else if (do_push) begin
                    head_q <= wdata;
                end
            end else if (do_push && empty) begin
                head_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Tracks E0/F0 prefixes across received bytes and queues make/break events.
//  state | meaning
//  IDLE  | no prefix pending; plain codes emit make events
//  S_E0  | E0 seen; next code is an extended make
//  S_F0  | F0 seen (ext may be set); next code is a break
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_done_tick,
    input  logic [7:0]                 din,
    ps2_scan_decoder_if.master         evt,
    output logic                       prefix_pending,
    output logic                       overflow
);

    localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    ps2_state_t    state, state_d;
    logic          ext, ext_d;
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
    logic          emit;
    ps2_evt_t      emit_evt;
    ps2_evt_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign pop = evt.evt_valid && evt.evt_ready;

    always_comb begin
        state_d   = state;
        ext_d     = ext;
        tmo_cnt_d = '0;
        emit      = 1'b0;
        emit_evt  = '{ext: 1'b0, brk: 1'b0, code: din};
        if (rx_done_tick) begin
            if (!is_filtered(din)) begin
                case (state)
                    IDLE: begin
                        if (din == PS2_EXT) begin
                            state_d = S_E0;
                            ext_d   = 1'b1;
                        end else if (din == PS2_BRK) begin
                            state_d = S_F0;
                            ext_d   = 1'b0;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    S_E0: begin
                        if (din == PS2_BRK) begin
                            state_d = S_F0;
                        end else if (din != PS2_EXT) begin
                            emit         = 1'b1;
                            emit_evt.ext = 1'b1;
                            state_d      = IDLE;
                            ext_d        = 1'b0;
                        end
                    end
                    S_F0: begin
                        if (din == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (din != PS2_BRK) begin
                            emit         = 1'b1;
                            emit_evt.ext = ext;
                            emit_evt.brk = 1'b1;
                            state_d      = IDLE;
                            ext_d        = 1'b0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        ext_d   = 1'b0;
                    end
                endcase
            end
        end else if (state != IDLE && TIMEOUT != 0) begin
            // A stale prefix is dropped silently once the wait budget is spent.
            if (tmo_cnt == TMO_LAST) begin
                state_d = IDLE;
                ext_d   = 1'b0;
            end else begin
                tmo_cnt_d = tmo_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            ext            <= 1'b0;
            tmo_cnt        <= '0;
            prefix_pending <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state          <= state_d;
            ext            <= ext_d;
            tmo_cnt        <= tmo_cnt_d;
            prefix_pending <= (state_d != IDLE);
            if (emit && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (emit),
        .wdata (emit_evt),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (head)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_code  = head.code;
    assign evt.evt_ext   = head.ext;
    assign evt.evt_brk   = head.brk;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder with DEPTH=4, TIMEOUT=16.
module tb_ps2_scan_decoder;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] din;
    logic       prefix_pending;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    ps2_scan_decoder_if evt_bus ();

    ps2_scan_decoder #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_done_tick   (rx_done_tick),
        .din            (din),
        .evt            (evt_bus),
        .prefix_pending (prefix_pending),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic [7:0] din;
        logic       ready;
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       pend;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic t, input logic [7:0] d, input logic r, input logic v,
                        input logic [7:0] c, input logic e, input logic b, input logic p);
        vec_t x;
        x.tick = t; x.din = d; x.ready = r; x.valid = v;
        x.code = c; x.ext = e; x.brk = b; x.pend = p;
        vq.push_back(x);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] c, input logic e,
                           input logic b, input logic p, input logic o);
        chk1({tag, " valid"}, evt_bus.evt_valid, v);
        chk8({tag, " code"},  evt_bus.evt_code,  c);
        chk1({tag, " ext"},   evt_bus.evt_ext,   e);
        chk1({tag, " brk"},   evt_bus.evt_brk,   b);
        chk1({tag, " pend"},  prefix_pending,    p);
        chk1({tag, " ovf"},   overflow,          o);
    endtask

    task automatic step(input logic t, input logic [7:0] d, input logic r);
        rx_done_tick      = t;
        din               = d;
        evt_bus.evt_ready = r;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset             = 1'b0;
        rx_done_tick      = 1'b0;
        evt_bus.evt_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_out(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_codes[4];

        reset             = 1'b1;
        rx_done_tick      = 1'b0;
        din               = 8'h00;
        evt_bus.evt_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset0");

        // tick din ready | valid code ext brk pend  (consumer always ready)
        addv(1, 8'h1C, 1,  1, 8'h1C, 0, 0, 0);
        addv(1, 8'hF0, 1,  0, 8'h1C, 0, 0, 1);
        addv(1, 8'h1C, 1,  1, 8'h1C, 0, 1, 0);
        addv(0, 8'h00, 1,  0, 8'h1C, 0, 1, 0);
        addv(1, 8'hE0, 1,  0, 8'h1C, 0, 1, 1);
        addv(1, 8'h75, 1,  1, 8'h75, 1, 0, 0);
        addv(1, 8'hE0, 1,  0, 8'h75, 1, 0, 1);
        addv(1, 8'hF0, 1,  0, 8'h75, 1, 0, 1);
        addv(1, 8'h75, 1,  1, 8'h75, 1, 1, 0);
        addv(1, 8'hE0, 1,  0, 8'h75, 1, 1, 1);
        addv(1, 8'hFA, 1,  0, 8'h75, 1, 1, 1);
        addv(1, 8'hF0, 1,  0, 8'h75, 1, 1, 1);
        addv(1, 8'h75, 1,  1, 8'h75, 1, 1, 0);
        addv(1, 8'hAA, 1,  0, 8'h75, 1, 1, 0);
        addv(1, 8'hF0, 1,  0, 8'h75, 1, 1, 1);
        addv(1, 8'hE0, 1,  0, 8'h75, 1, 1, 1);
        addv(1, 8'h6B, 1,  1, 8'h6B, 1, 1, 0);
        addv(1, 8'hE1, 1,  1, 8'hE1, 0, 0, 0);
        addv(1, 8'h14, 1,  1, 8'h14, 0, 0, 0);
        addv(1, 8'h77, 1,  1, 8'h77, 0, 0, 0);
        addv(0, 8'h00, 1,  0, 8'h77, 0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].tick, vq[i].din, vq[i].ready);
            chk_out($sformatf("vec%0d", i), vq[i].valid, vq[i].code, vq[i].ext,
                    vq[i].brk, vq[i].pend, 1'b0);
        end

        // Prefix timeout: E0 then 16 idle cycles returns to IDLE silently.
        do_reset("reset_tmo");
        step(1, 8'hE0, 0);
        chk1("tmo start pend", prefix_pending, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step(0, 8'h00, 0);
            chk1($sformatf("tmo pend k%0d", k), prefix_pending, (k < 16) ? 1'b1 : 1'b0);
        end
        step(1, 8'h1C, 0);
        chk_out("tmo make", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 8'h00, 1);
        chk1("tmo drained", evt_bus.evt_valid, 1'b0);

        // A filtered byte restarts the timeout.
        step(1, 8'hE0, 0);
        for (int k = 0; k < 10; k++) step(0, 8'h00, 0);
        step(1, 8'hFA, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 8'h00, 0);
            if (k >= 15) chk1($sformatf("tmo restart k%0d", k), prefix_pending, (k < 16) ? 1'b1 : 1'b0);
        end
        chk1("tmo restart ext", evt_bus.evt_valid, 1'b0);

        // Overflow: fifth event with no consumer is dropped.
        do_reset("reset_ovf");
        exp_codes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1, exp_codes[i], 0);
        chk_out("ovf full", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1, 8'h55, 0);
        chk_out("ovf drop", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk8($sformatf("ovf drain%0d", i), evt_bus.evt_code, exp_codes[i]);
            chk1($sformatf("ovf drain%0d valid", i), evt_bus.evt_valid, 1'b1);
            step(0, 8'h00, 1);
        end
        chk_out("ovf empty", 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full FIFO with simultaneous push and pop: nothing lost.
        do_reset("reset_pp");
        for (int i = 0; i < 4; i++) step(1, exp_codes[i], 0);
        step(1, 8'h55, 1);
        chk_out("pp head", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_codes = '{8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            chk8($sformatf("pp drain%0d", i), evt_bus.evt_code, exp_codes[i]);
            chk1($sformatf("pp drain%0d valid", i), evt_bus.evt_valid, 1'b1);
            step(0, 8'h00, 1);
        end
        chk_out("pp empty", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-sequence drops pending prefix and queued events.
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        chk_out("mid before", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset("mid reset");
        step(1, 8'h1C, 0);
        chk_out("mid make", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 8'h00, 1);
        chk1("mid only one", evt_bus.evt_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
